// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: MEM-stage opcodes, FSM encoding and byte-lane helpers for mem_bus_if.
// Lanes are big-endian: byte offset 0 maps to wb_sel_o[3] / data bits 31:24.
package mem_bus_pkg;

    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    localparam logic [3:0] SEL_NONE    = 4'b0000;
    localparam logic [3:0] SEL_WORD    = 4'b1111;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_BYTE0   = 4'b1000;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_byte(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_half(input logic [7:0] op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_word(input logic [7:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic [3:0] lane_sel(input logic [7:0] op, input logic [1:0] off);
        logic [3:0] sel;
        sel = SEL_NONE;
        if (is_byte(op))      sel = SEL_BYTE0 >> off;
        else if (is_half(op)) sel = off[1] ? SEL_HALF_LO : SEL_HALF_HI;
        else if (is_word(op)) sel = SEL_WORD;
        return sel;
    endfunction

    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] d);
        logic [31:0] res;
        res = 32'd0;
        if (op == OP_SB)      res = {4{d[7:0]}};
        else if (op == OP_SH) res = {2{d[15:0]}};
        else if (op == OP_SW) res = d;
        return res;
    endfunction

    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] off);
        return (is_half(op) && off[0]) || (is_word(op) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the addressed big-endian lane of a bus word and extends it per load op.
// Stores and non-access ops yield zero.
module mem_load_align
    import mem_bus_pkg::*;
(
    input  logic [7:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_data,
    output logic [31:0] o_result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[7:0];
        case (i_off)
            2'd0:    w_byte = i_data[31:24];
            2'd1:    w_byte = i_data[23:16];
            2'd2:    w_byte = i_data[15:8];
            default: w_byte = i_data[7:0];
        endcase
        w_half = i_off[1] ? i_data[15:0] : i_data[31:16];

        o_result = 32'd0;
        case (i_op)
            OP_LB:   o_result = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  o_result = {24'd0, w_byte};
            OP_LH:   o_result = {{16{w_half[15]}}, w_half};
            OP_LHU:  o_result = {16'd0, w_half};
            OP_LW:   o_result = i_data;
            default: o_result = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_bus_if.sv
// mem_bus_if: MEM-stage Wishbone master; states IDLE (no cycle) | BUSY (cycle open) | HOLD (result held).
// Define MEM_ALIGN_EXC_EN to trap misaligned half/word accesses instead of issuing them.
module mem_bus_if
    import mem_bus_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] reg2_i,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic [31:0] rdata_o,
    output logic        stallreq_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        exc_adel_o,
    output logic        exc_ades_o
);
    state_t      r_state;
    state_t      w_next;
    logic        r_cyc;
    logic        r_we;
    logic        r_flushed;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_rd_buf;
    logic [3:0]  r_sel;
    logic [7:0]  r_op;
    logic [1:0]  r_off;

    logic        w_idle;
    logic        w_access;
    logic        w_misal;
    logic        w_issue;
    logic        w_drop;
    logic [31:0] w_alg_data;
    logic [31:0] w_alg_result;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_access = is_load(aluop_i) | is_store(aluop_i);

`ifdef MEM_ALIGN_EXC_EN
    assign w_misal = misaligned(aluop_i, addr_i[1:0]);
`else
    assign w_misal = 1'b0;
`endif

    assign w_issue = w_idle & w_access & ~flush & ~w_misal & ~rst;
    // A flushed access still completes on the bus, but its data never reaches the pipeline.
    assign w_drop  = r_flushed | flush;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_next = ST_BUSY;
            ST_BUSY: if (wb_ack_i) w_next = (pipe_stall && !w_drop) ? ST_HOLD : ST_IDLE;
            ST_HOLD: if (!pipe_stall) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_alg_data = (r_state == ST_BUSY) ? wb_dat_i : r_rd_buf;

    always_comb begin
        stallreq_o = 1'b0;
        rdata_o    = 32'd0;
        case (r_state)
            ST_IDLE: stallreq_o = w_issue;
            ST_BUSY: begin
                stallreq_o = ~wb_ack_i & ~w_drop;
                if (wb_ack_i && !w_drop) rdata_o = w_alg_result;
            end
            ST_HOLD: rdata_o = w_alg_result;
            default: ;
        endcase
    end

    assign exc_adel_o = w_idle & w_misal & is_load(aluop_i)  & ~flush & ~rst;
    assign exc_ades_o = w_idle & w_misal & is_store(aluop_i) & ~flush & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 32'd0;
            r_dat     <= 32'd0;
            r_sel     <= SEL_NONE;
            r_rd_buf  <= 32'd0;
            r_op      <= 8'd0;
            r_off     <= 2'd0;
            r_flushed <= 1'b0;
        end else if (w_issue) begin
            r_cyc     <= 1'b1;
            r_we      <= is_store(aluop_i);
            r_adr     <= {addr_i[31:2], 2'b00};
            r_sel     <= lane_sel(aluop_i, addr_i[1:0]);
            r_dat     <= store_data(aluop_i, reg2_i);
            r_op      <= aluop_i;
            r_off     <= addr_i[1:0];
            r_flushed <= 1'b0;
        end else if (r_state == ST_BUSY) begin
            if (wb_ack_i) begin
                r_cyc     <= 1'b0;
                r_we      <= 1'b0;
                r_flushed <= 1'b0;
                if (!w_drop) r_rd_buf <= wb_dat_i;
            end else if (flush) begin
                r_flushed <= 1'b1;
            end
        end
    end

    assign wb_cyc_o = r_cyc;
    assign wb_stb_o = r_cyc;
    assign wb_we_o  = r_we;
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign wb_sel_o = r_sel;

    mem_load_align u_align (
        .i_op     (r_op),
        .i_off    (r_off),
        .i_data   (w_alg_data),
        .o_result (w_alg_result)
    );

endmodule

// File: tb/tb_mem_bus_if.sv
// tb_mem_bus_if: directed scenarios plus randomized traffic, checked every cycle against a
// transaction-level model of the MEM-stage bus master.
module tb_mem_bus_if;

    localparam logic [7:0] LB  = 8'hE0, LH  = 8'hE1, LW = 8'hE3, LBU = 8'hE4, LHU = 8'hE5;
    localparam logic [7:0] SB  = 8'hE8, SH  = 8'hE9, SW = 8'hEB, NOP = 8'h00;

`ifdef MEM_ALIGN_EXC_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk, rst;
    logic [7:0]  aluop_i;
    logic [31:0] addr_i, reg2_i, wb_dat_i;
    logic        flush, pipe_stall, wb_ack_i;
    logic [31:0] rdata_o, wb_adr_o, wb_dat_o;
    logic        stallreq_o, wb_we_o, wb_cyc_o, wb_stb_o, exc_adel_o, exc_ades_o;
    logic [3:0]  wb_sel_o;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] ops [9] = '{LB, LH, LW, LBU, LHU, SB, SH, SW, NOP};

    mem_bus_if dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .addr_i(addr_i), .reg2_i(reg2_i),
        .flush(flush), .pipe_stall(pipe_stall), .rdata_o(rdata_o), .stallreq_o(stallreq_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .exc_adel_o(exc_adel_o), .exc_ades_o(exc_ades_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          chk_en = 1'b0;
    bit          m_busy, m_hold, m_disc, m_cyc, m_we;
    logic [7:0]  m_op;
    logic [1:0]  m_off;
    logic [31:0] m_buf, m_adr, m_dat;
    logic [3:0]  m_sel;

    function automatic bit f_ld(input logic [7:0] op);
        return op inside {LB, LH, LW, LBU, LHU};
    endfunction

    function automatic bit f_st(input logic [7:0] op);
        return op inside {SB, SH, SW};
    endfunction

    function automatic bit f_mis(input logic [7:0] op, input logic [31:0] a);
        if (!ALIGN_EN) return 1'b0;
        if (op inside {LH, LHU, SH}) return a[0];
        if (op inside {LW, SW}) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [3:0] f_sel(input logic [7:0] op, input logic [31:0] a);
        if (op inside {LB, LBU, SB}) return 4'(8 >> a[1:0]);
        if (op inside {LH, LHU, SH}) return a[1] ? 4'b0011 : 4'b1100;
        if (op inside {LW, SW}) return 4'b1111;
        return 4'b0000;
    endfunction

    function automatic logic [31:0] f_wdat(input logic [7:0] op, input logic [31:0] d);
        if (op == SB) return {4{d[7:0]}};
        if (op == SH) return {2{d[15:0]}};
        if (op == SW) return d;
        return 32'd0;
    endfunction

    function automatic logic [31:0] f_ext(input logic [7:0] op, input logic [1:0] off,
                                          input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> (8 * (3 - int'(off))));
        h = off[1] ? d[15:0] : d[31:16];
        case (op)
            LB:      return {{24{b[7]}}, b};
            LBU:     return {24'd0, b};
            LH:      return {{16{h[15]}}, h};
            LHU:     return {16'd0, h};
            LW:      return d;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit f_issue();
        return !m_busy && !m_hold && (f_ld(aluop_i) || f_st(aluop_i)) && !flush &&
               !f_mis(aluop_i, addr_i) && !rst;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_hold = 0; m_disc = 0; m_cyc = 0; m_we = 0;
            m_adr = 0; m_dat = 0; m_sel = 0; m_buf = 0; m_op = 0; m_off = 0;
            chk_en = 1'b1;
        end else if (f_issue()) begin
            m_busy = 1; m_disc = 0; m_cyc = 1; m_we = f_st(aluop_i);
            m_adr = addr_i & 32'hFFFF_FFFC;
            m_sel = f_sel(aluop_i, addr_i);
            m_dat = f_wdat(aluop_i, reg2_i);
            m_op = aluop_i; m_off = addr_i[1:0];
        end else if (m_busy) begin
            if (wb_ack_i) begin
                m_busy = 0; m_cyc = 0; m_we = 0;
                if (!m_disc && !flush) begin
                    m_buf = wb_dat_i;
                    m_hold = pipe_stall;
                end
                m_disc = 0;
            end else if (flush) begin
                m_disc = 1;
            end
        end else if (m_hold && !pipe_stall) begin
            m_hold = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stallreq", stallreq_o,
                f_issue() || (m_busy && !wb_ack_i && !flush && !m_disc));
            chk("rdata", rdata_o,
                (m_busy && wb_ack_i && !flush && !m_disc) ? f_ext(m_op, m_off, wb_dat_i) :
                m_hold ? f_ext(m_op, m_off, m_buf) : 32'd0);
            chk("cyc", wb_cyc_o, m_cyc);
            chk("stb", wb_stb_o, m_cyc);
            chk("we", wb_we_o, m_we);
            chk("adr", wb_adr_o, m_adr);
            chk("sel", wb_sel_o, m_sel);
            chk("dat", wb_dat_o, m_dat);
            chk("adel", exc_adel_o, !m_busy && !m_hold && f_ld(aluop_i) &&
                f_mis(aluop_i, addr_i) && !flush && !rst);
            chk("ades", exc_ades_o, !m_busy && !m_hold && f_st(aluop_i) &&
                f_mis(aluop_i, addr_i) && !flush && !rst);
        end
    end

    // ---------------- stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1; aluop_i = NOP; addr_i = 0; reg2_i = 0; flush = 0; pipe_stall = 0;
        wb_dat_i = 0; wb_ack_i = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        smp();
        chk("rst_cyc", wb_cyc_o, 0);   chk("rst_adr", wb_adr_o, 0);
        chk("rst_sel", wb_sel_o, 0);   chk("rst_dat", wb_dat_o, 0);
        chk("rst_stall", stallreq_o, 0); chk("rst_rdata", rdata_o, 0);

        // LB at 0x103, two wait states
        nxt(); aluop_i = LB; addr_i = 32'h103;
        smp(); chk("lb_stall_issue", stallreq_o, 1);
        nxt(); smp();
        chk("lb_sel", wb_sel_o, 4'b0001); chk("lb_cyc", wb_cyc_o, 1);
        chk("lb_adr", wb_adr_o, 32'h100); chk("lb_stall_w1", stallreq_o, 1);
        nxt(); smp(); chk("lb_stall_w2", stallreq_o, 1);
        nxt(); wb_ack_i = 1; wb_dat_i = 32'h123456F0;
        smp(); chk("lb_stall_ack", stallreq_o, 0); chk("lb_rdata", rdata_o, 32'hFFFFFFF0);
        nxt(); wb_ack_i = 0; aluop_i = NOP;
        smp(); chk("lb_cyc_end", wb_cyc_o, 0); chk("lb_rdata_idle", rdata_o, 0);

        // SH at 0x202
        nxt(); aluop_i = SH; addr_i = 32'h202; reg2_i = 32'h0000BEEF;
        smp(); chk("sh_stall_issue", stallreq_o, 1);
        nxt(); wb_ack_i = 1; wb_dat_i = 32'h5555AAAA;
        smp();
        chk("sh_adr", wb_adr_o, 32'h200); chk("sh_sel", wb_sel_o, 4'b0011);
        chk("sh_dat", wb_dat_o, 32'hBEEFBEEF); chk("sh_we", wb_we_o, 1);
        chk("sh_stall_ack", stallreq_o, 0); chk("sh_rdata", rdata_o, 0);
        nxt(); wb_ack_i = 0; aluop_i = NOP;
        smp(); chk("sh_cyc_end", wb_cyc_o, 0); chk("sh_we_end", wb_we_o, 0);

        // LW completing into a 3-cycle pipeline stall
        nxt(); aluop_i = LW; addr_i = 32'h400;
        nxt(); wb_ack_i = 1; wb_dat_i = 32'hCAFEF00D; pipe_stall = 1;
        smp(); chk("lw_rdata_ack", rdata_o, 32'hCAFEF00D);
        nxt(); wb_ack_i = 0; wb_dat_i = 32'h11111111;
        smp(); chk("hold_rdata1", rdata_o, 32'hCAFEF00D); chk("hold_cyc1", wb_cyc_o, 0);
        chk("hold_stall1", stallreq_o, 0);
        nxt(); wb_ack_i = 1;
        smp(); chk("hold_rdata2", rdata_o, 32'hCAFEF00D); chk("hold_cyc2", wb_cyc_o, 0);
        nxt(); wb_ack_i = 0; pipe_stall = 0;
        smp(); chk("hold_rdata3", rdata_o, 32'hCAFEF00D);
        nxt(); aluop_i = NOP;
        smp(); chk("hold_exit_rdata", rdata_o, 0); chk("hold_exit_cyc", wb_cyc_o, 0);

        // flush while BUSY
        nxt(); aluop_i = LW; addr_i = 32'h500;
        nxt(); flush = 1;
        smp(); chk("fl_stall", stallreq_o, 0); chk("fl_cyc", wb_cyc_o, 1);
        nxt(); flush = 0; aluop_i = NOP;
        smp(); chk("fl_stall2", stallreq_o, 0); chk("fl_cyc2", wb_cyc_o, 1);
        nxt(); wb_ack_i = 1; wb_dat_i = 32'hDEADBEEF;
        smp(); chk("fl_rdata", rdata_o, 0); chk("fl_stall_ack", stallreq_o, 0);
        nxt(); wb_ack_i = 0;
        smp(); chk("fl_cyc_end", wb_cyc_o, 0);

        // flush while IDLE blocks issue
        nxt(); aluop_i = LB; addr_i = 32'h10; flush = 1;
        smp(); chk("fli_stall", stallreq_o, 0);
        nxt(); flush = 0; aluop_i = NOP;
        smp(); chk("fli_cyc", wb_cyc_o, 0);

        // misaligned LW at 0x301
        nxt(); aluop_i = LW; addr_i = 32'h301; wb_dat_i = 32'h0BADF00D;
        smp();
`ifdef MEM_ALIGN_EXC_EN
        chk("mis_adel", exc_adel_o, 1); chk("mis_stall", stallreq_o, 0);
        nxt(); aluop_i = NOP;
        smp(); chk("mis_cyc", wb_cyc_o, 0);
`else
        chk("mis_adel", exc_adel_o, 0); chk("mis_stall", stallreq_o, 1);
        nxt(); smp();
        chk("mis_cyc", wb_cyc_o, 1); chk("mis_adr", wb_adr_o, 32'h300);
        chk("mis_sel", wb_sel_o, 4'b1111);
        nxt(); wb_ack_i = 1;
        smp(); chk("mis_rdata", rdata_o, 32'h0BADF00D);
        nxt(); wb_ack_i = 0; aluop_i = NOP;
        smp(); chk("mis_cyc_end", wb_cyc_o, 0);
`endif

        // reset in the middle of a store
        nxt(); aluop_i = SW; addr_i = 32'h600; reg2_i = 32'h12345678;
        nxt(); smp();
        chk("rb_cyc", wb_cyc_o, 1); chk("rb_we", wb_we_o, 1); chk("rb_dat", wb_dat_o, 32'h12345678);
        nxt(); rst = 1;
        smp();
        nxt(); rst = 0; aluop_i = NOP; wb_ack_i = 1;
        smp();
        chk("rb_cyc0", wb_cyc_o, 0); chk("rb_stb0", wb_stb_o, 0); chk("rb_we0", wb_we_o, 0);
        chk("rb_adr0", wb_adr_o, 0); chk("rb_dat0", wb_dat_o, 0); chk("rb_sel0", wb_sel_o, 0);
        chk("rb_stall0", stallreq_o, 0); chk("rb_rdata0", rdata_o, 0);
        nxt(); wb_ack_i = 0;
        smp(); chk("rb_cyc_late", wb_cyc_o, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            rst        = ($urandom_range(0, 199) == 0);
            aluop_i    = ops[$urandom_range(0, 8)];
            addr_i     = $urandom;
            reg2_i     = $urandom;
            wb_dat_i   = $urandom;
            flush      = ($urandom_range(0, 9) == 0);
            pipe_stall = ($urandom_range(0, 2) == 0);
            wb_ack_i   = ($urandom_range(0, 2) == 0);
        end
        nxt(); rst = 0; aluop_i = NOP; flush = 0; wb_ack_i = 0;
        smp();
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_bus_if.md
MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 SHALL have clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have rst  in  1  synchronous reset, active-high (RstEnable=1); sampled on rising edge of clk only.
REQ-003 SHALL have aluop_i  in  8  MEM-stage op from EX/MEM register; load/store codes from package, all other codes = no access.
REQ-004 SHALL have addr_i  in  32  byte address; reg2_i  in  32  store source data.
REQ-005 SHALL have flush  in  1  pipeline flush; pipe_stall  in  1  MEM/WB register stalled this cycle.
REQ-006 SHALL have rdata_o  out  32  extended load result; stallreq_o  out  1  pipeline stall request.
REQ-007 SHALL have wb_adr_o 32, wb_dat_o 32, wb_sel_o 4, wb_we_o 1, wb_cyc_o 1, wb_stb_o 1  out  Wishbone master request.
REQ-008 SHALL have wb_dat_i  in  32  bus read data; wb_ack_i  in  1  bus acknowledge.
REQ-009 SHALL have exc_adel_o, exc_ades_o  out  1  load/store address-error flags (see Configuration).

Function
REQ-010 SHALL implement FSM states IDLE, BUSY, HOLD.
REQ-011 IDLE: SHALL go to BUSY on access op with flush=0; cyc/stb/we/adr/sel/dat registered at that edge; stallreq_o=1 combinationally in the same cycle.
REQ-012 wb_adr_o SHALL be {addr_i[31:2],2'b00}; big-endian lanes: byte offset 0 -> sel 4'b1000 / bits 31:24, offset 3 -> 4'b0001.
REQ-013 Byte op sel = one-hot by addr[1:0]; half op sel = 4'b1100 (addr[1]=0) or 4'b0011; word op sel = 4'b1111.
REQ-014 Store data SHALL be {4{reg2_i[7:0]}} for SB, {2{reg2_i[15:0]}} for SH, reg2_i for SW; wb_we_o=1 only for stores.
REQ-015 BUSY: stallreq_o=1 until wb_ack_i; on ack cycle stallreq_o=0 combinationally, rdata_o = extended wb_dat_i, wb_dat_i captured in rd_buf.
REQ-016 On ack edge SHALL deassert cyc/stb/we; next state HOLD if pipe_stall=1, else IDLE.
REQ-017 HOLD: rdata_o from rd_buf, stallreq_o=0, no new request; to IDLE when pipe_stall=0.
REQ-018 LB/LH SHALL sign-extend selected lane; LBU/LHU zero-extend; LW pass-through; stores drive rdata_o=0.
REQ-019 flush in IDLE SHALL block issue; flush in BUSY SHALL not abort cycle: cyc/stb held to ack, stallreq_o=0 from flush cycle, result discarded, then IDLE.
REQ-020 No access op, or state IDLE without issue: stallreq_o=0, rdata_o=0.
REQ-021 Back-to-back accesses SHALL insert at least one IDLE cycle with cyc=0 between bus cycles.

Reset
REQ-022 On rst: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o = 0; wb_adr_o, wb_dat_o, rd_buf = 0; wb_sel_o = 4'b0000; next-cycle rdata_o=0, stallreq_o=0, exc flags 0.
REQ-023 rst during BUSY SHALL drop cyc/stb at that edge; a later ack SHALL be ignored.

Configuration
REQ-024 Macro MEM_ALIGN_EXC_EN defined: misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) SHALL issue no bus cycle, assert exc_adel_o (load) or exc_ades_o (store) combinationally that cycle, stallreq_o=0.
REQ-025 Macro undefined: exc flags tied 0; halfword low bit and word low two bits ignored; access performed normally.

Structure
REQ-026 Package mem_bus_pkg SHALL hold aluop codes (LB 8'b11100000, LH 8'b11100001, LW 8'b11100011, LBU 8'b11100100, LHU 8'b11100101, SB 8'b11101000, SH 8'b11101001, SW 8'b11101011), FSM state encoding, sel constants.
REQ-027 Combinational sub-module mem_load_align SHALL perform lane select and extension; FSM and bus registers stay in mem_bus_if.

Verification
REQ-028 LB addr=0x103, ack after 2 wait cycles, wb_dat_i=0x123456F0 -> sel 0001, stallreq high 3 cycles, rdata_o=0xFFFFFFF0 in ack cycle.
REQ-029 SH addr=0x202, reg2=0x0000BEEF -> adr 0x200, sel 0011, dat 0xBEEFBEEF, we=1; ack next cycle -> IDLE.
REQ-030 LW, ack with pipe_stall=1 for 3 cycles -> HOLD, rdata_o stable at bus value, no new cyc, IDLE after stall release.
REQ-031 flush asserted in BUSY -> stallreq_o=0 immediately, cyc held until ack, rdata discarded, then IDLE.
REQ-032 MEM_ALIGN_EXC_EN defined, LW addr=0x301 -> exc_adel_o=1, wb_cyc_o stays 0; undefined -> access at 0x300, sel 1111.
REQ-033 rst asserted during BUSY -> cyc/stb 0 next edge, late ack ignored, all outputs at reset values.
